// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - add/subtract one 4-bit slice per cycle through a CLA cell
module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g  = x & y;
    assign p  = x ^ y;
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s = p ^ {c3, c2, c1, cin};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [3:0]    a_slice;
    logic [3:0]    b_slice;
    logic [3:0]    st_sum;
    logic          st_cout;
    logic          st_c3;
    logic [W-1:0]  slice_mask;
    logic [W-1:0]  sum_next;

    assign a_slice = 4'(a_q >> {cnt, 2'b00});
    assign b_slice = 4'(b_q >> {cnt, 2'b00});

    cla4 u_cla (
        .x    (a_slice),
        .y    (b_slice),
        .cin  (carry),
        .s    (st_sum),
        .cout (st_cout),
        .c3   (st_c3)
    );

    // Merge the fresh slice into the result so zero can be judged on the final word
    assign slice_mask = W'(4'hF) << {cnt, 2'b00};
    assign sum_next   = (sum_q & ~slice_mask) | (W'(st_sum) << {cnt, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        carry      <= bus.sub;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= sum_next;
                    carry <= st_cout;
                    if (cnt == LAST) begin
                        cout_q      <= st_cout;
                        ovf_q       <= st_cout ^ st_c3;
                        zero_q      <= (sum_next == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand set presented.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port a  input  W  operand A.
REQ-007 The block SHALL have port b  input  W  operand B.
REQ-008 The block SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-009 The block SHALL have port out_valid  output  1  result held on outputs.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-011 The block SHALL have port sum  output  W  result.
REQ-012 The block SHALL have port cout  output  1  carry out of MSB slice (for sub: 1 = no borrow).
REQ-013 The block SHALL have port ovf  output  1  signed overflow.
REQ-014 The block SHALL have port zero  output  1  sum == 0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 at a rising edge SHALL capture a, b (b inverted when sub=1), and initial carry = sub; clear the slice counter to 0; and move to RUN.
REQ-018 In RUN, each cycle SHALL add slice cnt of captured A and B plus the registered carry in one 4-bit carry-lookahead stage (the team's 4-bit CLA cell), and write the 4-bit result into sum[4*cnt+3:4*cnt].
REQ-019 In RUN, each cycle SHALL register the stage carry-out as the next carry-in and increment cnt.
REQ-020 On the edge processing cnt = NIBBLES-1, the block SHALL register cout = stage carry-out and ovf = stage carry-out XOR carry into bit 3 of that stage, then move to DONE.
REQ-021 Latency SHALL be exactly NIBBLES cycles: out_valid rises NIBBLES edges after the accepting edge.
REQ-022 zero SHALL equal (sum == 0) and SHALL be valid whenever out_valid=1.
REQ-023 In DONE, sum/cout/ovf/zero SHALL hold stable while out_ready=0.
REQ-024 In DONE, out_ready=1 at an edge SHALL complete the transfer and return the FSM to IDLE; no new operand is accepted on that same edge.
REQ-025 in_valid and operand changes while in RUN or DONE SHALL be ignored.
REQ-026 Arithmetic SHALL be modulo 2^W; A-B SHALL equal A + ~B + 1.
REQ-027 The slice counter SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1, and SHALL never exceed NIBBLES-1.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, cnt=0, sum=0, cout=0, ovf=0, zero=1, out_valid=0, in_ready=1, regardless of state.
REQ-029 rst SHALL take priority over every handshake; a reset during RUN or DONE SHALL discard the in-flight operation with no output transfer.

Verification
REQ-030 Test 1: 0xFFFF + 0x0001, sub=0 -> after 4 cycles, sum=0x0000, cout=1, ovf=0, zero=1.
REQ-031 Test 2: 0x7FFF + 0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-032 Test 3: 0x0005 - 0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 Test 4: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Test 5: rst asserted in the 2nd RUN cycle -> next cycle in IDLE with all outputs at reset values; the next operation (0x1234 + 0x1111) -> 0x2345.
REQ-035 Test 6: back-to-back operations with in_valid held high -> one acceptance per IDLE visit, each result correct; a/b changes during RUN do not affect the result.
